// File: rtl/mult32x32_pkg.sv
// Shared types and step constants for the 32x32 shift-add multiplier.
// The sequencer walks four A bytes against two B words.
package mult32x32_pkg;

    localparam int NUM_STEPS  = 8;
    localparam int SHIFT_UNIT = 8;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        S_A0B0 = 4'd1,
        S_A1B0 = 4'd2,
        S_A2B0 = 4'd3,
        S_A3B0 = 4'd4,
        S_A0B1 = 4'd5,
        S_A1B1 = 4'd6,
        S_A2B1 = 4'd7,
        S_A3B1 = 4'd8
    } state_t;

    // Byte x lands at 8*x, word y at 16*y: shift in bytes is x + 2*y.
    function automatic logic [2:0] step_shift(
        input logic [1:0] a_sel,
        input logic       b_sel
    );
        return {1'b0, a_sel} + {1'b0, b_sel, 1'b0};
    endfunction

endpackage

// File: rtl/mult32x32_fsm.sv
// Control sequencer for the 32x32 multiplier: eight accumulate steps,
// then a one-cycle done pulse from a registered flag.
module mult32x32_fsm
    import mult32x32_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [1:0] a_sel,
    output logic       b_sel,
    output logic [2:0] shift_sel,
    output logic       upd_prod,
    output logic       clr_prod
);

    state_t     state_q;
    state_t     state_d;
    logic       done_q;
    logic [2:0] step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_A3B1);
        end
    end

    // Step index 0..7 for S_A0B0..S_A3B1; wraps 8 -> 0 -> 7 via 3-bit math.
    assign step = state_q[2:0] - 3'd1;

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        upd_prod  = 1'b0;
        clr_prod  = 1'b0;
        a_sel     = 2'd0;
        b_sel     = 1'b0;
        shift_sel = 3'd0;
        done      = done_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = S_A0B0;
                    clr_prod = 1'b1;
                end
            end
            S_A0B0:  state_d = S_A1B0;
            S_A1B0:  state_d = S_A2B0;
            S_A2B0:  state_d = S_A3B0;
            S_A3B0:  state_d = S_A0B1;
            S_A0B1:  state_d = S_A1B1;
            S_A1B1:  state_d = S_A2B1;
            S_A2B1:  state_d = S_A3B1;
            S_A3B1:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            busy      = 1'b1;
            upd_prod  = 1'b1;
            a_sel     = step[1:0];
            b_sel     = step[2];
            shift_sel = step_shift(step[1:0], step[2]);
        end

        // Reset silences every output in the same cycle, not just after the edge.
        if (reset) begin
            busy      = 1'b0;
            done      = 1'b0;
            upd_prod  = 1'b0;
            clr_prod  = 1'b0;
            a_sel     = 2'd0;
            b_sel     = 1'b0;
            shift_sel = 3'd0;
        end
    end

endmodule

// File: tb/tb_mult32x32_fsm.sv
// Bench for mult32x32_fsm with a behavioural shift-add datapath;
// products are scoreboarded against a*b at every done pulse.
module tb_mult32x32_fsm;
    import mult32x32_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [2:0]  shift_sel;
    logic        upd_prod;
    logic        clr_prod;

    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [63:0] prod;
    logic [63:0] cur_exp;
    logic [7:0]  a_byte;
    logic [15:0] b_word;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int ndone;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] exp;
        int          cyc;
    } sb_t;

    vec_t vecs[8];
    sb_t  sbq[$];
    sb_t  e;

    always #5 clk = ~clk;

    mult32x32_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .shift_sel (shift_sel),
        .upd_prod  (upd_prod),
        .clr_prod  (clr_prod)
    );

    assign a_byte = a_in[8*a_sel +: 8];
    assign b_word = b_sel ? b_in[31:16] : b_in[15:0];

    always @(posedge clk) begin
        if (reset || clr_prod)
            prod <= 64'd0;
        else if (upd_prod)
            prod <= prod + ((64'(a_byte) * 64'(b_word)) << (SHIFT_UNIT * shift_sel));
    end

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endfunction

    function automatic logic [9:0] outs();
        return {busy, done, upd_prod, clr_prod, a_sel, b_sel, shift_sel};
    endfunction

    // Scoreboard: push on accepted start, pop and compare on done.
    always @(negedge clk) begin
        #2;
        cyc++;
        if (reset) begin
            sbq.delete();
        end else begin
            chk("upd_clr_exclusive", 64'(upd_prod & clr_prod), 64'd0);
            chk("shift_range", 64'(shift_sel > 3'd5), 64'd0);
            if (done) begin
                chk("done_expected", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("product", prod, e.exp);
                    chk("latency", 64'(cyc - e.cyc), 64'd9);
                end
            end
            if (sbq.size() != 0 && cyc - sbq[0].cyc > 9) begin
                chk("done_timeout", 64'(cyc - sbq[0].cyc), 64'd9);
                void'(sbq.pop_front());
            end
            if (start && !busy)
                sbq.push_back('{exp: cur_exp, cyc: cyc});
        end
    end

    task automatic run_pattern(input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp);
        logic [1:0] ea;
        logic       eb;
        @(negedge clk);
        a_in    = a;
        b_in    = b;
        cur_exp = exp;
        start   = 1'b1;
        #1;
        chk("accept", 64'({busy, upd_prod, clr_prod}), 64'b001);
        for (int s = 0; s < NUM_STEPS; s++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            ea = 2'(s % 4);
            eb = (s >= 4);
            chk("step", 64'(outs()),
                64'({1'b1, 1'b0, 1'b1, 1'b0, ea, eb, 3'(ea + 2 * eb)}));
        end
        @(negedge clk);
        #1;
        chk("done_cycle", 64'(outs()), 64'(10'b0100000000));
    endtask

    initial begin
        vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vecs[1] = '{32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080};
        vecs[2] = '{32'h00000000, 32'hFFFFFFFF, 64'h0};
        vecs[3] = '{32'h00000001, 32'hFFFFFFFF, 64'h00000000FFFFFFFF};
        vecs[4] = '{32'h80000000, 32'h00000002, 64'h0000000100000000};
        vecs[5] = '{32'h0000FFFF, 32'h00010000, 64'h00000000FFFF0000};
        vecs[6] = '{32'hDEADBEEF, 32'h00000100, 64'h000000DEADBEEF00};
        vecs[7].a = $urandom;
        vecs[7].b = $urandom;
        vecs[7].exp = 64'(vecs[7].a) * 64'(vecs[7].b);

        reset   = 1'b1;
        start   = 1'b1;
        a_in    = 32'd0;
        b_in    = 32'd0;
        cur_exp = 64'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", 64'(outs()), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 8; i++)
            run_pattern(vecs[i].a, vecs[i].b, vecs[i].exp);

        // Re-asserted start during steps 3-5 must be ignored.
        @(negedge clk);
        a_in    = 32'hCAFEF00D;
        b_in    = 32'h01234567;
        cur_exp = 64'(a_in) * 64'(b_in);
        start   = 1'b1;
        ndone   = 0;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            start = (i >= 3 && i <= 5);
            #1;
            if (done) ndone++;
            if (i >= 3 && i <= 5)
                chk("ignored_start_clr", 64'(clr_prod), 64'd0);
        end
        start = 1'b0;
        chk("single_done", 64'(ndone), 64'd1);

        // Reset in S_A2B0 aborts the sequence without a done.
        @(negedge clk);
        a_in    = 32'h0BADC0DE;
        b_in    = 32'hFEEDFACE;
        cur_exp = 64'(a_in) * 64'(b_in);
        start   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        chk("mid_a_sel", 64'(a_sel), 64'd2);
        reset = 1'b1;
        #1;
        chk("mid_reset_outs", 64'(outs()), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_outs", 64'(outs()), 64'd0);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (done) ndone++;
        end
        chk("no_done_after_abort", 64'(ndone), 64'd0);
        run_pattern(32'h0BADC0DE, 32'hFEEDFACE, 64'(32'h0BADC0DE) * 64'(32'hFEEDFACE));

        // Start held high: back-to-back sequences every 9 cycles.
        @(negedge clk);
        a_in    = 32'h89ABCDEF;
        b_in    = 32'h76543210;
        cur_exp = 64'(a_in) * 64'(b_in);
        start   = 1'b1;
        ndone   = 0;
        for (int i = 1; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                ndone++;
                chk("clr_with_done", 64'(clr_prod), 64'd1);
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("held_done_count", 64'(ndone), 64'd3);
        repeat (12) @(negedge clk);
        #3;
        chk("queue_drained", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
